// File: rtl/operand_bypass_unit_pkg.sv
// Shared opcode constants, immediate formats and tracker flag type for the
// ID/EX operand bypass unit and decode.
package operand_bypass_unit_pkg;

   localparam logic [6:0] OP_ALU = 7'b0110011;
   localparam logic [6:0] ALUopI = 7'b0010011;
   localparam logic [6:0] LW     = 7'b0000011;
   localparam logic [6:0] SW     = 7'b0100011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;

   typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_S, IMM_U} imm_fmt_t;

   // Per-stage producer flags; rd and captured value live beside it so their
   // widths can follow the unit's parameters.
   typedef struct packed {
      logic valid;
      logic is_load;
   } trk_flags_t;

   function automatic imm_fmt_t imm_fmt(input logic [6:0] op);
      case (op)
         ALUopI, LW, JALR: return IMM_I;
         SW:               return IMM_S;
         LUI, AUIPC:       return IMM_U;
         default:          return IMM_NONE;
      endcase
   endfunction

   function automatic logic uses_rs1(input logic [6:0] op);
      return !(op == LUI || op == AUIPC || op == JAL);
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      return !(op == ALUopI || op == LW || op == JALR);
   endfunction

endpackage

// File: rtl/operand_bypass_unit_imm_gen.sv
// Combinational immediate extraction from opcode and instruction word;
// shared with decode.
module operand_bypass_unit_imm_gen
   import operand_bypass_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [6:0]      op,
   input  logic [31:0]     ir,
   output logic            use_imm,
   output logic [XLEN-1:0] imm
);

   logic signed [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (imm_fmt(op))
         IMM_I:   imm32 = {{20{ir[31]}}, ir[31:20]};
         IMM_S:   imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         IMM_U:   imm32 = {ir[31:12], 12'b0};
         default: imm32 = '0;
      endcase
   end

   assign use_imm = (imm_fmt(op) != IMM_NONE);
   assign imm     = XLEN'(imm32);

endmodule

// File: rtl/operand_bypass_unit.sv
// ID/EX operand forwarding with a one-cycle load-use interlock; tracks the
// last DEPTH issued producers and registers resolved operands into EX.
module operand_bypass_unit
   import operand_bypass_unit_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 3,
   parameter int RA_W    = 5
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             flush,
   input  logic                             issue_valid,
   output logic                             issue_ready,
   input  logic [6:0]                       issue_op,
   input  logic [31:0]                      issue_ir,
   input  logic [RA_W-1:0]                  issue_rd,
   input  logic [NUM_SRC-1:0][RA_W-1:0]     issue_rs,
   input  logic [NUM_SRC-1:0][XLEN-1:0]     rf_data,
   input  logic [XLEN-1:0]                  ex_result,
   input  logic [XLEN-1:0]                  mem_rdata,
   output logic                             out_valid,
   output logic [6:0]                       out_op,
   output logic [XLEN-1:0]                  out_a,
   output logic [XLEN-1:0]                  out_b,
   output logic [XLEN-1:0]                  out_c,
   output logic [RA_W-1:0]                  out_rd
);

   localparam int C_IDX = (NUM_SRC == 3) ? 2 : 1;

   trk_flags_t [DEPTH-1:0]           trk;
   logic       [DEPTH-1:0][RA_W-1:0] trk_rd;
   logic       [DEPTH-1:1][XLEN-1:0] trk_val;
   logic       [XLEN-1:0]            e1_val;

   logic [NUM_SRC-1:0][XLEN-1:0] src_val;
   logic [NUM_SRC-1:0]           src_ld_hit;
   logic [NUM_SRC-1:0]           src_used;
   logic                         stall, accept, use_imm;
   logic [XLEN-1:0]              imm;
   logic                         unused_ir;

   assign unused_ir = ^issue_ir[6:0];
   assign e1_val    = trk[1].is_load ? mem_rdata : trk_val[1];

   // Oldest match applied first so the youngest producer overrides it.
   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      logic [XLEN-1:0] val;
      logic            ld_hit;
      always_comb begin
         val    = rf_data[s];
         ld_hit = 1'b0;
         for (int k = DEPTH-1; k >= 2; k--)
            if (trk[k].valid && trk_rd[k] == issue_rs[s]) val = trk_val[k];
         if (trk[1].valid && trk_rd[1] == issue_rs[s]) val = e1_val;
         if (trk[0].valid && trk_rd[0] == issue_rs[s]) begin
            val    = ex_result;
            ld_hit = trk[0].is_load;
         end
         if (issue_rs[s] == '0) begin
            val    = '0;
            ld_hit = 1'b0;
         end
      end
      assign src_val[s]    = val;
      assign src_ld_hit[s] = ld_hit;
   end

   always_comb begin
      src_used    = '1;
      src_used[0] = uses_rs1(issue_op);
      src_used[1] = uses_rs2(issue_op);
   end

   // Stall depends only on tracker tags, never on ex_result/mem_rdata.
   assign stall       = issue_valid && |(src_used & src_ld_hit);
   assign issue_ready = flush || !stall;
   assign accept      = issue_valid && !stall && !flush;

   operand_bypass_unit_imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .op      (issue_op),
      .ir      (issue_ir),
      .use_imm (use_imm),
      .imm     (imm)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trk     <= '0;
         trk_rd  <= '0;
         trk_val <= '0;
      end else begin
         trk[0]     <= '{valid: accept && (issue_rd != '0), is_load: (issue_op == LW)};
         trk_rd[0]  <= issue_rd;
         trk_val[1] <= ex_result;
         for (int k = 1; k < DEPTH; k++) begin
            trk[k]    <= trk[k-1];
            trk_rd[k] <= trk_rd[k-1];
         end
         for (int k = 2; k < DEPTH; k++)
            trk_val[k] <= (k == 2) ? e1_val : trk_val[k-1];
         if (flush)
            for (int k = 0; k < DEPTH; k++) trk[k].valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_op    <= '0;
         out_a     <= '0;
         out_b     <= '0;
         out_c     <= '0;
         out_rd    <= '0;
      end else begin
         out_valid <= accept;
         if (accept) begin
            out_op <= issue_op;
            out_a  <= src_val[0];
            out_b  <= use_imm ? imm : src_val[1];
            out_c  <= src_val[C_IDX];
            out_rd <= issue_rd;
         end
      end
   end

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Directed vector bench for operand_bypass_unit: forwarding, load-use stall,
// immediates, flush and asynchronous reset mid-stall.
module tb_operand_bypass_unit;
   import operand_bypass_unit_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic              issue_valid = 1'b0;
   logic              issue_ready;
   logic [6:0]        issue_op = '0;
   logic [31:0]       issue_ir = '0;
   logic [4:0]        issue_rd = '0;
   logic [1:0][4:0]   issue_rs = '0;
   logic [1:0][31:0]  rf_data = '0;
   logic [31:0]       ex_result = '0;
   logic [31:0]       mem_rdata = '0;
   logic              out_valid;
   logic [6:0]        out_op;
   logic [31:0]       out_a, out_b, out_c;
   logic [4:0]        out_rd;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   operand_bypass_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_op    (issue_op),
      .issue_ir    (issue_ir),
      .issue_rd    (issue_rd),
      .issue_rs    (issue_rs),
      .rf_data     (rf_data),
      .ex_result   (ex_result),
      .mem_rdata   (mem_rdata),
      .out_valid   (out_valid),
      .out_op      (out_op),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_c       (out_c),
      .out_rd      (out_rd)
   );

   typedef struct {
      logic        vld, fl;
      logic [6:0]  op;
      logic [31:0] ir;
      logic [4:0]  rd, rs0, rs1;
      logic [31:0] rf0, rf1, ex, mem;
      logic        rdy, ov;
      logic [31:0] a, b, c;
   } vec_t;

   localparam int NV = 21;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic vld, input logic fl, input logic [6:0] op,
                               input logic [31:0] ir, input logic [4:0] rd, input logic [4:0] rs0,
                               input logic [4:0] rs1, input logic [31:0] rf0, input logic [31:0] rf1,
                               input logic [31:0] ex, input logic [31:0] mem, input logic rdy,
                               input logic ov, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c);
      vec_t v;
      v.vld = vld; v.fl = fl; v.op = op; v.ir = ir; v.rd = rd; v.rs0 = rs0; v.rs1 = rs1;
      v.rf0 = rf0; v.rf1 = rf1; v.ex = ex; v.mem = mem; v.rdy = rdy; v.ov = ov;
      v.a = a; v.b = b; v.c = c;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      issue_valid = v.vld; flush = v.fl; issue_op = v.op; issue_ir = v.ir; issue_rd = v.rd;
      issue_rs[0] = v.rs0; issue_rs[1] = v.rs1; rf_data[0] = v.rf0; rf_data[1] = v.rf1;
      ex_result = v.ex; mem_rdata = v.mem;
   endtask

   initial begin
      //           vld fl op      ir            rd  rs0 rs1 rf0           rf1           ex            mem           rdy ov a             b             c
      tbl[0]  = mk(1, 0, OP_ALU, 32'h0,        5,  1,  2,  32'h1,        32'h2,        32'h0,        32'h0,        1,  1, 32'h1,        32'h2,        32'h2);
      tbl[1]  = mk(1, 0, OP_ALU, 32'h0,        6,  5,  5,  32'h99,       32'h99,       32'h10,       32'h0,        1,  1, 32'h10,       32'h10,       32'h10);
      tbl[2]  = mk(1, 0, LW,     32'h0,        7,  0,  0,  32'h0,        32'h0,        32'h11,       32'h0,        1,  1, 32'h0,        32'h0,        32'h0);
      tbl[3]  = mk(1, 0, OP_ALU, 32'h0,        8,  7,  3,  32'h66,       32'h3,        32'h100,      32'h0,        0,  0, 32'h0,        32'h0,        32'h0);
      tbl[4]  = mk(1, 0, OP_ALU, 32'h0,        8,  7,  3,  32'h66,       32'h3,        32'h0,        32'hDEADBEEF, 1,  1, 32'hDEADBEEF, 32'h3,        32'h3);
      tbl[5]  = mk(1, 0, OP_ALU, 32'h0,        5,  0,  0,  32'h0,        32'h0,        32'h20,       32'h0,        1,  1, 32'h0,        32'h0,        32'h0);
      tbl[6]  = mk(0, 0, OP_ALU, 32'h0,        0,  0,  0,  32'h0,        32'h0,        32'h12345678, 32'h0,        1,  0, 32'h0,        32'h0,        32'h0);
      tbl[7]  = mk(1, 0, SW,     32'hFE52AE23, 0,  5,  5,  32'h55,       32'h55,       32'h0,        32'h0,        1,  1, 32'h12345678, 32'hFFFFFFFC, 32'h12345678);
      tbl[8]  = mk(1, 0, OP_ALU, 32'h0,        9,  0,  0,  32'h0,        32'h0,        32'h0,        32'h0,        1,  1, 32'h0,        32'h0,        32'h0);
      tbl[9]  = mk(1, 0, OP_ALU, 32'h0,        10, 0,  0,  32'h0,        32'h0,        32'h1,        32'h0,        1,  1, 32'h0,        32'h0,        32'h0);
      tbl[10] = mk(1, 0, OP_ALU, 32'h0,        9,  0,  0,  32'h0,        32'h0,        32'h5,        32'h0,        1,  1, 32'h0,        32'h0,        32'h0);
      tbl[11] = mk(1, 0, OP_ALU, 32'h0,        11, 9,  0,  32'h77,       32'h77,       32'h2,        32'h0,        1,  1, 32'h2,        32'h0,        32'h0);
      tbl[12] = mk(1, 0, OP_ALU, 32'h0,        0,  0,  0,  32'h77,       32'h77,       32'h0,        32'h0,        1,  1, 32'h0,        32'h0,        32'h0);
      tbl[13] = mk(1, 0, OP_ALU, 32'h0,        12, 0,  0,  32'h77,       32'h77,       32'h9,        32'h0,        1,  1, 32'h0,        32'h0,        32'h0);
      tbl[14] = mk(1, 0, OP_ALU, 32'h0,        13, 1,  1,  32'h3,        32'h3,        32'h0,        32'h0,        1,  1, 32'h3,        32'h3,        32'h3);
      tbl[15] = mk(1, 0, OP_ALU, 32'h0,        14, 2,  2,  32'h4,        32'h4,        32'h6,        32'h0,        1,  1, 32'h4,        32'h4,        32'h4);
      tbl[16] = mk(1, 1, OP_ALU, 32'h0,        15, 12, 13, 32'h1,        32'h1,        32'hBAD,      32'h0,        1,  0, 32'h0,        32'h0,        32'h0);
      tbl[17] = mk(1, 0, OP_ALU, 32'h0,        16, 13, 14, 32'hAAAA0000, 32'hAAAA0000, 32'hBAD,      32'hBAD,      1,  1, 32'hAAAA0000, 32'hAAAA0000, 32'hAAAA0000);
      tbl[18] = mk(1, 0, LW,     32'h0,        20, 0,  0,  32'h0,        32'h0,        32'h0,        32'h0,        1,  1, 32'h0,        32'h0,        32'h0);
      tbl[19] = mk(1, 1, OP_ALU, 32'h0,        21, 20, 0,  32'h42,       32'h0,        32'h0,        32'h0,        1,  0, 32'h0,        32'h0,        32'h0);
      tbl[20] = mk(1, 0, OP_ALU, 32'h0,        21, 20, 0,  32'h42,       32'h0,        32'h0,        32'h0,        1,  1, 32'h42,       32'h0,        32'h0);

      #12;
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_a", out_a, 32'h0);
      chk("rst_b", out_b, 32'h0);
      chk("rst_ready", 32'(issue_ready), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         drive(tbl[i]);
         #3;
         chk($sformatf("r%0d_ready", i), 32'(issue_ready), 32'(tbl[i].rdy));
         @(posedge clk);
         #1;
         chk($sformatf("r%0d_valid", i), 32'(out_valid), 32'(tbl[i].ov));
         if (tbl[i].ov) begin
            chk($sformatf("r%0d_a", i), out_a, tbl[i].a);
            chk($sformatf("r%0d_b", i), out_b, tbl[i].b);
            chk($sformatf("r%0d_c", i), out_c, tbl[i].c);
            chk($sformatf("r%0d_op", i), 32'(out_op), 32'(tbl[i].op));
            chk($sformatf("r%0d_rd", i), 32'(out_rd), 32'(tbl[i].rd));
         end
      end

      // Reset asserted while a load-use stall is pending.
      drive(mk(1, 0, LW, 32'h00400383, 7, 1, 0, 32'h50, 32'h0, 32'h0, 32'h0, 1, 1, 32'h50, 32'h4, 32'h0));
      @(posedge clk);
      #1;
      chk("ld_a", out_a, 32'h50);
      chk("ld_b", out_b, 32'h4);
      drive(mk(1, 0, OP_ALU, 32'h0, 8, 7, 3, 32'h66, 32'h3, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0));
      #2;
      chk("stall_ready", 32'(issue_ready), 32'h0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", 32'(out_valid), 32'h0);
      chk("mrst_op", 32'(out_op), 32'h0);
      chk("mrst_a", out_a, 32'h0);
      chk("mrst_b", out_b, 32'h0);
      chk("mrst_c", out_c, 32'h0);
      chk("mrst_rd", 32'(out_rd), 32'h0);
      chk("mrst_ready", 32'(issue_ready), 32'h1);
      #2;
      rst_n = 1'b1;
      #1;
      chk("post_ready", 32'(issue_ready), 32'h1);
      @(posedge clk);
      #1;
      chk("post_valid", 32'(out_valid), 32'h1);
      chk("post_a", out_a, 32'h66);
      chk("post_b", out_b, 32'h3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
